// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB encodings and master FSM state type
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ADDR, ST_DATA} mst_state_e;
endpackage

// File: rtl/ahb_wait_timer.sv
// ahb_wait_timer: clearable data-phase wait counter with timeout flag
// ports: hclk/hreset clock and sync reset; clr zeroes the count; inc counts one
// wait cycle; timeout is high on the wait cycle that brings the count to TIMEOUT_CYC
module ahb_wait_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic hclk,
  input  logic hreset,
  input  logic clr,
  input  logic inc,
  output logic timeout
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr ? '0 : inc ? cnt_q + 1'b1 : cnt_q;
    timeout = inc && (cnt_q == CW'(TIMEOUT_CYC - 1));
  end
  always_ff @(posedge hclk) begin
    if (hreset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ahb_master.sv
// ahb_master: single-transfer AHB master driven by a command/response handshake
// ports: cmd_* command in (cmd_ready handshake); hreq/hgrant/sel arbiter link;
// haddr/htrans/hwrite/hsize/hwdata/hrdata/hready/hresp AHB bus; rsp_* one-cycle completion
module ahb_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [1:0]        cmd_sel,
  output logic              hreq,
  input  logic              hgrant,
  output logic [1:0]        sel,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  mst_state_e st_q, st_d;
  logic [ADDR_W-1:0] addr_q, addr_d, haddr_q, haddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, hwdata_q, hwdata_d, rdata_q, rdata_d;
  logic [1:0] csel_q, csel_d, sel_q, sel_d, htrans_q, htrans_d;
  logic write_q, write_d, hwrite_q, hwrite_d, ready_q, ready_d, hreq_q, hreq_d;
  logic vld_q, vld_d, err_q, err_d, timeout, unal;
  assign unal = cmd_addr[1:0] != 2'b00;
  ahb_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .hclk    (hclk),
    .hreset  (hreset),
    .clr     (st_q != ST_DATA),
    .inc     (st_q == ST_DATA && !hready),
    .timeout (timeout)
  );
  // outputs are computed from the next state so every bus signal comes straight off a flop
  always_comb begin
    st_d = st_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    csel_d = csel_q;
    vld_d = 1'b0;
    err_d = HRESP_OKAY;
    rdata_d = '0;
    case (st_q)
      ST_IDLE: if (cmd_valid && ready_q) begin
        addr_d = cmd_addr;
        wdata_d = cmd_wdata;
        write_d = cmd_write;
        csel_d = cmd_sel;
        st_d = unal ? ST_IDLE : ST_REQ;
        vld_d = unal;
        err_d = unal ? HRESP_ERROR : HRESP_OKAY;
      end
      ST_REQ: st_d = (hgrant && hready) ? ST_ADDR : ST_REQ;
      ST_ADDR: st_d = !hgrant ? ST_REQ : hready ? ST_DATA : ST_ADDR;
      ST_DATA: if (hready || timeout) begin
        st_d = ST_IDLE;
        vld_d = 1'b1;
        err_d = hready ? hresp : HRESP_ERROR;
        rdata_d = (hready && !write_q) ? hrdata : '0;
      end
      default: st_d = ST_IDLE;
    endcase
    ready_d = st_d == ST_IDLE && !vld_d;
    hreq_d = st_d != ST_IDLE;
    sel_d = hreq_d ? csel_d : 2'b00;
    htrans_d = st_d == ST_ADDR ? HTRANS_NONSEQ : HTRANS_IDLE;
    haddr_d = st_d == ST_ADDR ? addr_d : '0;
    hwrite_d = st_d == ST_ADDR && write_d;
    hwdata_d = (st_d == ST_DATA && write_d) ? wdata_d : '0;
  end
  always_ff @(posedge hclk) begin
    if (hreset) begin
      st_q <= ST_IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      csel_q <= 2'b00;
      ready_q <= 1'b1;
      hreq_q <= 1'b0;
      sel_q <= 2'b00;
      htrans_q <= HTRANS_IDLE;
      haddr_q <= '0;
      hwrite_q <= 1'b0;
      hwdata_q <= '0;
      vld_q <= 1'b0;
      rdata_q <= '0;
      err_q <= HRESP_OKAY;
    end else begin
      st_q <= st_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      csel_q <= csel_d;
      ready_q <= ready_d;
      hreq_q <= hreq_d;
      sel_q <= sel_d;
      htrans_q <= htrans_d;
      haddr_q <= haddr_d;
      hwrite_q <= hwrite_d;
      hwdata_q <= hwdata_d;
      vld_q <= vld_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  assign cmd_ready = ready_q;
  assign hreq = hreq_q;
  assign sel = sel_q;
  assign htrans = htrans_q;
  assign haddr = haddr_q;
  assign hwrite = hwrite_q;
  assign hsize = HSIZE_WORD;
  assign hwdata = hwdata_q;
  assign rsp_valid = vld_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err = err_q;
endmodule

// File: tb/tb_ahb_master.sv
// tb_ahb_master: directed scoreboard bench for ahb_master with a simple slave/arbiter model
module tb_ahb_master;
  logic hclk, hreset, cmd_valid, cmd_ready, cmd_write, hreq, hgrant, hwrite, hready, hresp;
  logic rsp_valid, rsp_err;
  logic [31:0] cmd_addr, cmd_wdata, haddr, hwdata, hrdata, rsp_rdata;
  logic [1:0] cmd_sel, sel, htrans;
  logic [2:0] hsize;
  int n_chk = 0, n_fail = 0;
  int hreq_cnt = 0, ns_cnt = 0, rsp_cnt = 0;
  logic [31:0] last_hwdata;
  logic [1:0] last_sel;
  logic [32:0] sb[$];
  int wait_n = 0, scnt = 0;
  logic err_mode = 1'b0, dphase = 1'b0;
  logic [31:0] rd_val = '0;

  ahb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .hclk(hclk), .hreset(hreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
    .hreq(hreq), .hgrant(hgrant), .sel(sel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata), .hready(hready),
    .hresp(hresp), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // arbiter grants in the same cycle it sees hreq, i.e. one cycle after hreq is raised
  assign hgrant = hreq;
  // slave: data phase starts after an accepted NONSEQ, inserts wait_n wait states
  assign hready = !dphase || (scnt >= wait_n);
  assign hresp = dphase && err_mode;
  assign hrdata = (dphase && hready) ? rd_val : 32'h0;
  always @(posedge hclk) begin
    if (hreset) begin
      dphase <= 1'b0;
      scnt <= 0;
    end else if (dphase) begin
      if (hready) dphase <= 1'b0;
      else scnt <= scnt + 1;
    end else if (htrans == 2'b10 && hready && hgrant) begin
      dphase <= 1'b1;
      scnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge hclk) begin
    if (hreq) begin
      hreq_cnt++;
      last_sel = sel;
    end
    if (htrans == 2'b10) ns_cnt++;
    if (dphase && hready) last_hwdata = hwdata;
    if (rsp_valid) begin
      rsp_cnt++;
      if (sb.size() == 0) chk("sb_unexpected_rsp", 64'(sb.size()), 64'd1);
      else begin
        logic [32:0] e;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e[31:0]);
        chk("rsp_err", rsp_err, e[32]);
      end
    end
  end

  task automatic chk_reset(input string p);
    chk({p, "_cmd_ready"}, cmd_ready, 1);
    chk({p, "_hreq"}, hreq, 0);
    chk({p, "_sel"}, sel, 0);
    chk({p, "_haddr"}, haddr, 0);
    chk({p, "_htrans"}, htrans, 0);
    chk({p, "_hwrite"}, hwrite, 0);
    chk({p, "_hsize"}, hsize, 3'b010);
    chk({p, "_hwdata"}, hwdata, 0);
    chk({p, "_rsp_valid"}, rsp_valid, 0);
    chk({p, "_rsp_rdata"}, rsp_rdata, 0);
    chk({p, "_rsp_err"}, rsp_err, 0);
  endtask

  task automatic run_cmd(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input int exp_lat, input int exp_hreq, input int exp_ns,
                         input logic [32:0] exp);
    int lat, h0, n0, r0;
    sb.push_back(exp);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_wdata = d;
    cmd_sel = s;
    @(posedge hclk);
    #1 cmd_valid = 1'b0;
    h0 = hreq_cnt;
    n0 = ns_cnt;
    r0 = rsp_cnt;
    lat = 0;
    do begin
      @(negedge hclk);
      #1 lat++;
    end while (!rsp_valid && lat < 60);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_hreq_cycles"}, 64'(hreq_cnt - h0), 64'(exp_hreq));
    chk({tag, "_nonseq_cycles"}, 64'(ns_cnt - n0), 64'(exp_ns));
    chk({tag, "_ready_in_rsp"}, cmd_ready, 0);
    chk({tag, "_hreq_in_rsp"}, hreq, 0);
    @(posedge hclk);
    #1;
    chk({tag, "_rsp_one_cycle"}, rsp_valid, 0);
    chk({tag, "_ready_after"}, cmd_ready, 1);
    chk({tag, "_rsp_count"}, 64'(rsp_cnt - r0), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    hreset = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    cmd_sel = '0;
    repeat (2) @(posedge hclk);
    #1 chk_reset("reset");
    hreset = 1'b0;
    @(posedge hclk);
    #1;
    run_cmd("write", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'd2, 4, 3, 1, {1'b0, 32'h0});
    chk("write_hwdata", last_hwdata, 32'hDEAD_BEEF);
    chk("write_sel", last_sel, 2'd2);
    wait_n = 3;
    rd_val = 32'h1234_5678;
    run_cmd("read_wait", 1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 2'd1, 7, 6, 1, {1'b0, 32'h1234_5678});
    chk("read_hwdata", last_hwdata, 32'h0);
    chk("read_sel", last_sel, 2'd1);
    wait_n = 1;
    err_mode = 1'b1;
    rd_val = 32'h0;
    run_cmd("read_error", 1'b0, 32'h0000_0030, 32'h0, 2'd3, 5, 4, 1, {1'b1, 32'h0});
    err_mode = 1'b0;
    wait_n = 20;
    rd_val = 32'hCAFE_F00D;
    run_cmd("timeout", 1'b0, 32'h0000_0040, 32'h0, 2'd0, 19, 18, 1, {1'b1, 32'h0});
    for (int i = 0; i < 40 && dphase; i++) begin
      @(posedge hclk);
      #1;
    end
    chk("slave_done", dphase, 0);
    wait_n = 0;
    run_cmd("unaligned", 1'b1, 32'h0000_0013, 32'h55, 2'd1, 1, 0, 0, {1'b1, 32'h0});
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 32'h0000_0050;
    cmd_wdata = 32'hA5A5_A5A5;
    cmd_sel = 2'd2;
    @(posedge hclk);
    #1 cmd_valid = 1'b0;
    r0 = rsp_cnt;
    for (int i = 0; i < 10 && htrans !== 2'b10; i++) begin
      @(posedge hclk);
      #1;
    end
    chk("rst_reach_addr", htrans, 2'b10);
    chk("rst_addr_haddr", haddr, 32'h0000_0050);
    chk("rst_addr_hwrite", hwrite, 1);
    hreset = 1'b1;
    @(posedge hclk);
    #1 chk_reset("midreset");
    hreset = 1'b0;
    repeat (3) begin
      @(posedge hclk);
      #1;
    end
    chk("midreset_no_rsp", 64'(rsp_cnt - r0), 64'd0);
    chk("midreset_hreq", hreq, 0);
    chk("midreset_ready", cmd_ready, 1);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_master.md
AHB_MASTER -- requirements
Module: ahb_master

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width.
REQ-003 Parameter TIMEOUT_CYC, default 16, SHALL set the maximum number of consecutive hready-low data-phase cycles.
REQ-004 Ports SHALL be, as name, direction, width, meaning:
  hclk  in  1  sole clock, rising edge
  hreset  in  1  synchronous reset, active-high
  cmd_valid  in  1  command request
  cmd_ready  out  1  command accepted when high with cmd_valid
  cmd_write  in  1  1=write, 0=read
  cmd_addr  in  ADDR_W  byte address
  cmd_wdata  in  DATA_W  write data
  cmd_sel  in  2  target slave select
  hreq  out  1  bus request to arbiter
  hgrant  in  1  grant from arbiter
  sel  out  2  slave select presented to arbiter
  haddr  out  ADDR_W  AHB address
  htrans  out  2  AHB transfer type
  hwrite  out  1  AHB direction
  hsize  out  3  AHB size
  hwdata  out  DATA_W  AHB write data
  hrdata  in  DATA_W  AHB read data
  hready  in  1  transfer-done from selected slave
  hresp  in  1  0=OKAY, 1=ERROR
  rsp_valid  out  1  one-cycle completion pulse
  rsp_rdata  out  DATA_W  read data, valid with rsp_valid
  rsp_err  out  1  error flag, valid with rsp_valid

Function
REQ-005 FSM states SHALL be IDLE, REQ, ADDR, DATA; single transfers only, no bursts.
REQ-006 IDLE: cmd_ready=1; on cmd_valid, capture cmd_* into registers; the next state is REQ, or IDLE with the reject of REQ-012 if cmd_addr[1:0]!=0.
REQ-007 REQ: hreq=1, sel=captured cmd_sel, htrans=IDLE; on hgrant=1 and hready=1, go to ADDR.
REQ-008 ADDR: htrans=2'b10 (NONSEQ), haddr=captured address, hwrite=captured write, hsize=3'b010, hreq=1; on hready=1 and hgrant=1, go to DATA; on hgrant=0, go back to REQ.
REQ-009 DATA: htrans=IDLE; hwdata=captured wdata when write, else 0; hreq=1 until completion.
REQ-010 Completion in DATA: on hready=1, the following cycle SHALL have rsp_valid=1, rsp_err=hresp, rsp_rdata=hrdata (read) or 0 (write); state returns to IDLE and hreq=0.
REQ-011 Wait counter: clears on DATA entry; increments on each DATA cycle with hready=0. When it reaches TIMEOUT_CYC, the block SHALL complete with rsp_err=1 and rsp_rdata=0, then go to IDLE.
REQ-012 Unaligned command (cmd_addr[1:0]!=0): hreq SHALL NOT assert; rsp_valid=1 and rsp_err=1 SHALL be given the cycle after acceptance.
REQ-013 Two-cycle ERROR response (hready=0/hresp=1, then hready=1/hresp=1): completion SHALL occur only on the hready=1 cycle, with rsp_err=1.
REQ-014 cmd_ready SHALL be 0 in REQ, ADDR, DATA, and in the cycle rsp_valid is high; cmd_valid there SHALL be ignored.
REQ-015 Command-to-response latency SHALL be 4 cycles minimum: accept, REQ, ADDR, DATA, then rsp_valid. This assumes a grant one cycle after hreq and zero wait states.
REQ-016 rsp_valid SHALL be high for exactly one cycle per accepted command.
REQ-017 All outputs SHALL be registered.

Reset
REQ-018 With hreset=1 at a rising hclk edge, the state SHALL be IDLE, the counter 0, and outputs SHALL be: cmd_ready=1, hreq=0, sel=0, haddr=0, htrans=2'b00, hwrite=0, hsize=3'b010, hwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-019 Reset mid-transfer SHALL abandon the transfer with no rsp_valid; the next cycle SHALL show the reset values.

Structure
REQ-020 A shared package ahb_pkg SHALL hold: HTRANS_IDLE/NONSEQ, HSIZE_WORD, HRESP_OKAY/ERROR, and the master state encoding.
REQ-021 One sub-module, ahb_wait_timer, SHALL implement the clearable wait counter and timeout flag.

Verification
REQ-022 Write 0x0000_0010/0xDEADBEEF, sel=2, grant 1 cycle after hreq, hready=1 -> hreq high 3 cycles, NONSEQ 1 cycle, hwdata=0xDEADBEEF, rsp_valid at cycle 4, rsp_err=0.
REQ-023 Read 0x20, slave inserts 3 wait states, hrdata=0x12345678 -> rsp_valid 3 cycles later than REQ-022, rsp_rdata=0x12345678.
REQ-024 Read 0x30, two-cycle ERROR response -> rsp_err=1, exactly one rsp_valid pulse.
REQ-025 hready held 0 for 20 cycles in DATA, TIMEOUT_CYC=16 -> rsp_err=1 after 16 wait cycles, hreq=0 next cycle.
REQ-026 cmd_addr=0x0000_0013 -> no hreq, rsp_valid with rsp_err=1 next cycle; a second case sets hreset=1 in ADDR -> reset values, no rsp_valid.
